// File: rtl/reg_bank_mp_pkg.sv
// risc_rf_pkg: shared defaults and types for the multi-port register bank.
//   RF_DW       default register data width
//   RF_NREG     default register count (power of 2)
//   RF_AW       default register address width
//   RF_DONE_REG default index of the register whose bit 0 flags completion
//   reg_t / raddr_t  register word and address types at the default sizes
package risc_rf_pkg;

  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_NREG     = 32;
  localparam int unsigned RF_AW       = $clog2(RF_NREG);
  localparam int unsigned RF_DONE_REG = 30;

  typedef logic [RF_DW-1:0] reg_t;
  typedef logic [RF_AW-1:0] raddr_t;

endpackage

// File: rtl/reg_bank_mp_if.sv
// reg_bank_mp_if: bus bundle of the register bank (everything except clk/reset).
//   rd_addr      packed read addresses, port i at [i*AW +: AW]
//   rd_data      packed read data, port i at [i*DW +: DW]
//   rd_busy      scoreboard bit of each addressed register
//   wa_*         write port A (ALU/EX)
//   wb_*         write port B (late load/MEM); wb_en also clears busy[wb_addr]
//   sb_set/addr  mark a register busy (load issued)
//   program_done sticky completion flag
// Modports: master (CPU side, drives addresses/writes), slave (register bank).
interface reg_bank_mp_if
  import risc_rf_pkg::*;
#(
  parameter int unsigned DW     = RF_DW,
  parameter int unsigned NREG   = RF_NREG,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 wa_en;
  logic [AW-1:0]        wa_addr;
  logic [DW-1:0]        wa_data;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [DW-1:0]        wb_data;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic                 program_done;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr,
    input  rd_data, rd_busy, program_done
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr,
    output rd_data, rd_busy, program_done
  );

endinterface

// File: rtl/reg_bank_mp_rf_read_port.sv
// rf_read_port: one combinational read port of the register bank.
//   raddr        read address
//   stored_data  stored word of the addressed register (looked up by the top)
//   busy_vec     full scoreboard vector
//   wa_*/wb_*    write ports, used for same-cycle forwarding
//   sb_*         scoreboard set, used to keep busy visible on a set/clear clash
//   rd_data      read data
//   rd_busy      scoreboard bit of the addressed register
// Build option: REG_BYPASS_EN enables same-cycle write-to-read forwarding;
// without it the port returns stored state only.
module rf_read_port #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0]   raddr,
  input  logic [DW-1:0]   stored_data,
  input  logic [NREG-1:0] busy_vec,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [DW-1:0]   wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_busy
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  always_comb begin
    rd_data = stored_data;
    rd_busy = busy_vec[raddr];
`ifdef REG_BYPASS_EN
    // B first so that A overrides it on a same-address dual write.
    if (wb_en && (wb_addr == raddr)) rd_data = wb_data;
    if (wa_en && (wa_addr == raddr)) rd_data = wa_data;
    // A same-cycle sb_set to this register wins over the clear.
    if (wb_en && (wb_addr == raddr) && !(sb_set && (sb_addr == raddr)))
      rd_busy = 1'b0;
`endif
    if (ZERO_EN && (raddr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

`ifndef REG_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
                           sb_set, sb_addr};
`endif

endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: parametrised multi-port CPU register file.
//   clk    clock, rising edge
//   reset  synchronous, active-high; clears registers, scoreboard and done flag
//   bus    reg_bank_mp_if.slave: NUM_RD async read ports (rd_addr/rd_data/
//          rd_busy), write ports A and B, scoreboard set, program_done
// Parameters: DW, NREG (power of 2), NUM_RD (1..4), ZERO_REG (1: r0 hardwired
// to zero), DONE_REG (register whose bit 0 signals completion).
// Build option: REG_BYPASS_EN adds same-cycle write-to-read forwarding in the
// read ports.
module reg_bank_mp
  import risc_rf_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned DONE_REG = RF_DONE_REG
) (
  input logic         clk,
  input logic         reset,
  reg_bank_mp_if.slave bus
);

  localparam int unsigned AW       = $clog2(NREG);
  localparam bit          ZERO_EN  = (ZERO_REG != 0);
  localparam logic [AW-1:0] DONE_IDX = AW'(DONE_REG);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic            done_q;

  logic wa_ok;
  logic wb_ok;
  logic sb_ok;

  assign wa_ok = bus.wa_en  && !(ZERO_EN && (bus.wa_addr == '0));
  assign wb_ok = bus.wb_en  && !(ZERO_EN && (bus.wb_addr == '0));
  assign sb_ok = bus.sb_set && !(ZERO_EN && (bus.sb_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      busy   <= '0;
      done_q <= 1'b0;
    end else begin
      // B is written first so port A wins a same-address dual write.
      if (wb_ok) regs[bus.wb_addr] <= bus.wb_data;
      if (wa_ok) regs[bus.wa_addr] <= bus.wa_data;
      // Clear before set: a same-cycle set to the same register wins.
      if (bus.wb_en) busy[bus.wb_addr] <= 1'b0;
      if (sb_ok)     busy[bus.sb_addr] <= 1'b1;
      if (regs[DONE_IDX][0]) done_q <= 1'b1;
    end
  end

  assign bus.program_done = done_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rbusy;

    assign raddr = bus.rd_addr[g*AW +: AW];

    rf_read_port #(
      .DW       (DW),
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .raddr       (raddr),
      .stored_data (regs[raddr]),
      .busy_vec    (busy),
      .wa_en       (bus.wa_en),
      .wa_addr     (bus.wa_addr),
      .wa_data     (bus.wa_data),
      .wb_en       (bus.wb_en),
      .wb_addr     (bus.wb_addr),
      .wb_data     (bus.wb_data),
      .sb_set      (bus.sb_set),
      .sb_addr     (bus.sb_addr),
      .rd_data     (rdata),
      .rd_busy     (rbusy)
    );

    assign bus.rd_data[g*DW +: DW] = rdata;
    assign bus.rd_busy[g]          = rbusy;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
`timescale 1ns/1ps
// tb_reg_bank_mp: directed plus randomized checks of reg_bank_mp (defaults:
// DW=32, NREG=32, NUM_RD=2, ZERO_REG=1, DONE_REG=30) against a behavioural
// model of the register file. Honours REG_BYPASS_EN when it is defined.
module tb_reg_bank_mp;
  import risc_rf_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned AW     = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_bank_mp_if #(.DW(DW), .NREG(NREG), .NUM_RD(NUM_RD)) bus ();

  reg_bank_mp #(
    .DW       (DW),
    .NREG     (NREG),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1),
    .DONE_REG (30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model: architectural register contents, busy set, done flag.
  reg_t m_reg  [NREG];
  bit   m_busy [NREG];
  bit   m_done;

  int tests = 0;
  int fails = 0;

  function automatic reg_t exp_rd(input int a);
    if (a == 0) return '0;
`ifdef REG_BYPASS_EN
    if (bus.wa_en && int'(bus.wa_addr) == a) return bus.wa_data;
    if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
`endif
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REG_BYPASS_EN
    if (bus.wb_en && int'(bus.wb_addr) == a &&
        !(bus.sb_set && int'(bus.sb_addr) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr[0 +: AW]  = AW'(a0);
    bus.rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic check_model(input string tag);
    int   a;
    reg_t od;
    logic ob;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      a  = int'(bus.rd_addr[p*AW +: AW]);
      od = bus.rd_data[p*DW +: DW];
      ob = bus.rd_busy[p];
      tests++;
      assert (od === exp_rd(a)) else begin
        fails++;
        $error("FAIL %s rd_data%0d addr=%0d got=%h exp=%h", tag, p, a, od, exp_rd(a));
      end
      tests++;
      assert (ob === exp_busy(a)) else begin
        fails++;
        $error("FAIL %s rd_busy%0d addr=%0d got=%b exp=%b", tag, p, a, ob, exp_busy(a));
      end
    end
    tests++;
    assert (bus.program_done === m_done) else begin
      fails++;
      $error("FAIL %s program_done got=%b exp=%b", tag, bus.program_done, m_done);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit nd;
    int wa, wb, sb;
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_done = 1'b0;
    end else begin
      nd = m_done | m_reg[30][0];
      wa = int'(bus.wa_addr);
      wb = int'(bus.wb_addr);
      sb = int'(bus.sb_addr);
      if (bus.wb_en && wb != 0) m_reg[wb] = bus.wb_data;
      if (bus.wa_en && wa != 0) m_reg[wa] = bus.wa_data;
      if (bus.wb_en) m_busy[wb] = 1'b0;
      if (bus.sb_set && sb != 0) m_busy[sb] = 1'b1;
      m_done = nd;
    end
  endtask

  // Inputs are already applied; check, advance the model, take the edge.
  task automatic step(input string tag);
    check_model(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 3))
        0: return 0;
        1: return 7;
        2: return 9;
        default: return 30;
      endcase
    end
    return int'($urandom_range(0, NREG - 1));
  endfunction

  task automatic rand_inputs();
    bus.wa_en   = 1'($urandom_range(0, 1));
    bus.wa_addr = AW'(pick_addr());
    bus.wa_data = $urandom;
    bus.wb_en   = 1'($urandom_range(0, 1));
    bus.wb_addr = AW'(pick_addr());
    bus.wb_data = $urandom;
    bus.sb_set  = 1'($urandom_range(0, 1));
    bus.sb_addr = AW'(pick_addr());
    set_rd(pick_addr(), pick_addr());
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rd(0, 0);
    @(posedge clk);
    #1;
    model_edge();

    // 1: reset after random traffic clears everything
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      settle();
      step("rand_pre");
    end
    reset = 1'b1;
    rand_inputs();
    settle();
    step("rst_cycle");
    reset = 1'b0;
    idle();
    for (int a = 0; a < int'(NREG); a += 2) begin
      set_rd(a, a + 1);
      settle();
      check_val("rst_data0", bus.rd_data[0 +: DW], 32'h0);
      check_val("rst_data1", bus.rd_data[DW +: DW], 32'h0);
      check_val("rst_busy", {30'b0, bus.rd_busy}, 32'h0);
      check_val("rst_done", {31'b0, bus.program_done}, 32'h0);
      step("rst_scan");
    end

    // 2: write r5 while reading it
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEADBEEF;
    set_rd(5, 0);
    settle();
`ifdef REG_BYPASS_EN
    check_val("fwd_same_cycle", bus.rd_data[0 +: DW], 32'hDEADBEEF);
`else
    check_val("old_same_cycle", bus.rd_data[0 +: DW], 32'h0);
`endif
    step("t2_write");
    idle();
    settle();
    check_val("r5_after", bus.rd_data[0 +: DW], 32'hDEADBEEF);
    step("t2_read");

    // 3: dual write to r7, A wins
    bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h22;
    set_rd(7, 7);
    settle();
    step("t3_write");
    idle();
    settle();
    check_val("dual_a_wins", bus.rd_data[DW +: DW], 32'h11);
    step("t3_read");

    // 4: scoreboard on r9
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    set_rd(0, 9);
    settle();
    step("t4_set");
    idle();
    settle();
    check_val("busy_set", {31'b0, bus.rd_busy[1]}, 32'h1);
    step("t4_hold");
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55;
    settle();
`ifdef REG_BYPASS_EN
    check_val("busy_fwd_clr", {31'b0, bus.rd_busy[1]}, 32'h0);
`else
    check_val("busy_pre_clr", {31'b0, bus.rd_busy[1]}, 32'h1);
`endif
    step("t4_clear");
    idle();
    settle();
    check_val("busy_cleared", {31'b0, bus.rd_busy[1]}, 32'h0);
    check_val("r9_load", bus.rd_data[DW +: DW], 32'h55);
    step("t4_after");
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    settle();
    step("t4_reset_busy");
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h66;
    settle();
    check_val("set_clr_clash_now", {31'b0, bus.rd_busy[1]}, 32'h1);
    step("t4_clash");
    idle();
    settle();
    check_val("set_wins", {31'b0, bus.rd_busy[1]}, 32'h1);
    step("t4_clash_after");

    // 5: r0 is hardwired
    bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFF_FFFF;
    set_rd(0, 0);
    settle();
    check_val("r0_write_now", bus.rd_data[0 +: DW], 32'h0);
    step("t5_write");
    idle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    settle();
    check_val("r0_after_write", bus.rd_data[0 +: DW], 32'h0);
    step("t5_sb");
    idle();
    settle();
    check_val("r0_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    step("t5_after");

    // 6: program_done
    bus.wa_en = 1'b1; bus.wa_addr = 5'd30; bus.wa_data = 32'h1;
    set_rd(30, 0);
    settle();
    step("t6_write");
    idle();
    settle();
    check_val("done_not_yet", {31'b0, bus.program_done}, 32'h0);
    step("t6_wait");
    settle();
    check_val("done_set", {31'b0, bus.program_done}, 32'h1);
    bus.wa_en = 1'b1; bus.wa_addr = 5'd30; bus.wa_data = 32'h0;
    step("t6_clear_bit");
    idle();
    step("t6_idle1");
    settle();
    check_val("done_sticky", {31'b0, bus.program_done}, 32'h1);
    reset = 1'b1;
    step("t6_reset");
    reset = 1'b0;
    settle();
    check_val("done_reset", {31'b0, bus.program_done}, 32'h0);
    step("t6_after_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      rand_inputs();
      settle();
      step("rand");
    end
    reset = 1'b0;
    idle();
    for (int a = 0; a < int'(NREG); a += 2) begin
      set_rd(a, a + 1);
      settle();
      step("final_scan");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
